// File: rtl/product_accumulator.sv
// Registered adder tree plus vector accumulator for the multiplier array's product beats.
// Define PRODUCT_ACCUMULATOR_RELU_EN to clamp negative results to zero when the result is loaded.
module product_accumulator #(
   parameter int unsigned array_size = 16,
   parameter int unsigned num_width  = 8,
   parameter int unsigned acc_width  = 40,
   parameter int unsigned cnt_width  = 8
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [2*num_width*array_size-1:0] in_prod,
   input  logic                              in_last,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [acc_width-1:0]              out_sum,
   output logic [cnt_width-1:0]              out_beats,
   output logic                              overflow,
   output logic                              busy
);

   localparam int unsigned PW     = 2 * num_width;
   localparam int unsigned Levels = $clog2(array_size);
   localparam int unsigned TW     = PW + Levels;

   typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

   state_e state_q, state_d;

   logic                  stall;
   logic                  advance;
   logic [Levels:1]       tree_vld_q;
   logic [Levels:1]       tree_last_q;
   logic                  tree_vld;
   logic                  tree_last;
   logic [TW-1:0]         tree_sum;
   logic [acc_width-1:0]  tree_ext;
   logic [acc_width-1:0]  acc_q;
   logic [acc_width-1:0]  acc_sum;
   logic [acc_width-1:0]  final_sum;
   logic                  add_ovf;
   logic                  ovf_q;
   logic [cnt_width-1:0]  cnt_q;
   logic [cnt_width-1:0]  cnt_inc;
   logic [acc_width-1:0]  out_sum_q;
   logic [cnt_width-1:0]  out_beats_q;
   logic                  out_ovf_q;

   // The whole pipeline freezes while a result is offered but not taken.
   assign stall    = out_valid & ~out_ready;
   assign advance  = ~stall;
   assign in_ready = ~stall;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tree_vld_q  <= '0;
         tree_last_q <= '0;
      end else if (advance) begin
         tree_vld_q[1]  <= in_valid;
         tree_last_q[1] <= in_last;
         for (int k = 2; k <= int'(Levels); k++) begin
            tree_vld_q[k]  <= tree_vld_q[k-1];
            tree_last_q[k] <= tree_last_q[k-1];
         end
      end
   end

   // Level k holds array_size>>k partial sums, each one bit wider than the level below.
   for (genvar k = 1; k <= int'(Levels); k++) begin : g_lvl
      localparam int unsigned N = array_size >> k;
      localparam int unsigned W = PW + k;
      for (genvar i = 0; i < int'(N); i++) begin : g_node
         logic [W-2:0] a;
         logic [W-2:0] b;
         logic [W-1:0] sum_q;
         if (k == 1) begin : g_leaf
            assign a = in_prod[(2*i)*PW +: PW];
            assign b = in_prod[(2*i+1)*PW +: PW];
         end else begin : g_inner
            assign a = g_lvl[k-1].g_node[2*i].sum_q;
            assign b = g_lvl[k-1].g_node[2*i+1].sum_q;
         end
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               sum_q <= '0;
            end else if (advance) begin
               sum_q <= {a[W-2], a} + {b[W-2], b};
            end
         end
      end
   end

   assign tree_vld  = tree_vld_q[Levels];
   assign tree_last = tree_last_q[Levels];
   assign tree_sum  = g_lvl[Levels].g_node[0].sum_q;

   if (acc_width > TW) begin : g_ext
      assign tree_ext = {{(acc_width-TW){tree_sum[TW-1]}}, tree_sum};
   end else begin : g_trunc
      assign tree_ext = tree_sum[acc_width-1:0];
   end

   assign acc_sum = acc_q + tree_ext;
   assign add_ovf = (acc_q[acc_width-1] == tree_ext[acc_width-1]) &&
                    (acc_sum[acc_width-1] != acc_q[acc_width-1]);
   assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

`ifdef PRODUCT_ACCUMULATOR_RELU_EN
   assign final_sum = acc_sum[acc_width-1] ? '0 : acc_sum;
`else
   assign final_sum = acc_sum;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StAccum: begin
            if (tree_vld) state_d = tree_last ? StHold : StAccum;
         end
         StHold: begin
            if (out_ready) begin
               if (tree_vld) state_d = tree_last ? StHold : StAccum;
               else          state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      out_valid = (state_q == StHold);
      busy      = (|tree_vld_q) | (state_q != StIdle);
      out_sum   = out_sum_q;
      out_beats = out_beats_q;
      overflow  = out_ovf_q;
   end

   // Accumulator clears as the result is captured, so the next beat starts from zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         out_sum_q   <= '0;
         out_beats_q <= '0;
         out_ovf_q   <= 1'b0;
      end else if (advance && tree_vld) begin
         if (tree_last) begin
            out_sum_q   <= final_sum;
            out_beats_q <= cnt_inc;
            out_ovf_q   <= ovf_q | add_ovf;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
         end else begin
            acc_q <= acc_sum;
            cnt_q <= cnt_inc;
            ovf_q <= ovf_q | add_ovf;
         end
      end
   end

endmodule

// File: tb/tb_product_accumulator.sv
// Randomised and directed bench for product_accumulator against a plain-arithmetic vector model.
// Honors PRODUCT_ACCUMULATOR_RELU_EN in its expected values.
module tb_product_accumulator;

   localparam int ARRAY = 16;
   localparam int NW    = 8;
   localparam int ACC_W = 20;
   localparam int CNT_W = 4;
   localparam int PW    = 2 * NW;
   localparam int VW    = PW * ARRAY;
   localparam int RES_W = ACC_W + CNT_W + 1;

   typedef struct packed {
      logic [VW-1:0] v;
      logic          last;
   } beat_t;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [VW-1:0]    in_prod;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_sum;
   logic [CNT_W-1:0] out_beats;
   logic             overflow;
   logic             busy;

   product_accumulator #(
      .array_size(ARRAY),
      .num_width (NW),
      .acc_width (ACC_W),
      .cnt_width (CNT_W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_prod  (in_prod),
      .in_last  (in_last),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_sum  (out_sum),
      .out_beats(out_beats),
      .overflow (overflow),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int               n_cmp = 0;
   int               n_err = 0;
   longint           cyc = 0;
   logic [RES_W-1:0] got_q[$];
   logic [RES_W-1:0] exp_q[$];
   longint           got_cyc[$];
   logic [VW-1:0]    beats_q[$];
   beat_t            drv_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         got_q.push_back({out_sum, out_beats, overflow});
         got_cyc.push_back(cyc);
      end
   end

   function automatic logic [VW-1:0] fill(input logic [PW-1:0] x);
      logic [VW-1:0] r;
      for (int i = 0; i < ARRAY; i++) r[i*PW +: PW] = x;
      return r;
   endfunction

   function automatic logic [VW-1:0] rand_vec(input int mag);
      logic [VW-1:0] r;
      int            p;
      for (int i = 0; i < ARRAY; i++) begin
         p = int'($urandom_range(2 * mag, 0)) - mag;
         r[i*PW +: PW] = p[PW-1:0];
      end
      return r;
   endfunction

   function automatic longint beat_sum(input logic [VW-1:0] v);
      logic signed [PW-1:0] p;
      longint               s = 0;
      for (int i = 0; i < ARRAY; i++) begin
         p = v[i*PW +: PW];
         s += p;
      end
      return s;
   endfunction

   // Model: running signed sum wrapped to ACC_W bits, sticky flag when the true sum leaves range.
   task automatic model_vector();
      longint acc  = 0;
      longint t;
      longint amax = (longint'(1) << (ACC_W - 1)) - 1;
      longint amin = -(longint'(1) << (ACC_W - 1));
      longint res;
      bit     ov   = 1'b0;
      int     n    = beats_q.size();
      int     nb;
      beat_t  it;
      for (int j = 0; j < n; j++) begin
         t = acc + beat_sum(beats_q[j]);
         if (t > amax || t < amin) ov = 1'b1;
         t = t & ((longint'(1) << ACC_W) - 1);
         if (t > amax) t -= (longint'(1) << ACC_W);
         acc = t;
         it.v = beats_q[j];
         it.last = (j == n - 1);
         drv_q.push_back(it);
      end
      nb  = (n > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : n;
      res = acc;
`ifdef PRODUCT_ACCUMULATOR_RELU_EN
      if (res < 0) res = 0;
`endif
      exp_q.push_back({res[ACC_W-1:0], nb[CNT_W-1:0], ov});
      beats_q.delete();
   endtask

   // Called at posedge+1; returns at posedge+1 after the last beat is taken.
   task automatic drive_all(output int stalls);
      beat_t it;
      int    guard;
      stalls = 0;
      while (drv_q.size() > 0) begin
         it = drv_q.pop_front();
         in_valid = 1'b1;
         in_prod  = it.v;
         in_last  = it.last;
         @(negedge clk);
         guard = 0;
         while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
            stalls++;
         end
         if (guard >= 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL drive_timeout: in_ready still %0b, required 1", in_ready);
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_results(output bit ok);
      int guard = 0;
      while (got_q.size() < exp_q.size() && guard < 400) begin
         @(negedge clk);
         guard++;
      end
      ok = (got_q.size() >= exp_q.size());
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b, required 0", out_valid); end
      n_cmp++; if (out_sum !== '0) begin n_err++; $display("FAIL reset_out_sum: got %0d, required 0", out_sum); end
      n_cmp++; if (out_beats !== '0) begin n_err++; $display("FAIL reset_out_beats: got %0d, required 0", out_beats); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %0b, required 0", overflow); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b, required 0", busy); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0b, required 1", in_ready); end
   endtask

   task automatic test_single_beat();
      int               st;
      int               lat = 1;
      bit               ok;
      logic [RES_W-1:0] e, g;
      beats_q.push_back(fill(16'd3));
      model_vector();
      drive_all(st);
      while (lat < 50) begin
         @(negedge clk);
         if (out_valid) break;
         @(posedge clk);
         lat++;
      end
      n_cmp++;
      if (lat !== 5) begin n_err++; $display("FAIL single_latency: got %0d cycles, required 5", lat); end
      wait_results(ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL single_timeout: got %0d results, required %0d", got_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         n_cmp++;
         if (g !== e || g !== {20'd48, 4'd1, 1'b0})
            begin n_err++; $display("FAIL single_result: got sum=%0d beats=%0d ovf=%0b, required sum=48 beats=1 ovf=0",
                                   $signed(g[RES_W-1 -: ACC_W]), g[CNT_W:1], g[0]); end
      end
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_idle: got %0b, required 0", busy); end
   endtask

   task automatic test_three_beat();
      int               st;
      bit               ok;
      logic [RES_W-1:0] e, g;
      for (int v = 0; v < 2; v++) begin
         beats_q.push_back(fill(16'd1));
         beats_q.push_back(fill(16'd2));
         beats_q.push_back(fill(16'hFFFF));
         model_vector();
      end
      drive_all(st);
      n_cmp++;
      if (st !== 0) begin n_err++; $display("FAIL three_beat_stalls: got %0d stall cycles, required 0", st); end
      wait_results(ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL three_beat_timeout: got %0d results, required %0d", got_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         n_cmp++;
         if (g !== e || g[RES_W-1 -: ACC_W] !== 20'd32)
            begin n_err++; $display("FAIL three_beat_result: got sum=%0d beats=%0d ovf=%0b, required sum=%0d beats=%0d ovf=%0b",
                                   $signed(g[RES_W-1 -: ACC_W]), g[CNT_W:1], g[0], $signed(e[RES_W-1 -: ACC_W]), e[CNT_W:1], e[0]); end
      end
   endtask

   task automatic test_back_to_back();
      int               st;
      bit               ok;
      logic [RES_W-1:0] e, g;
      got_cyc.delete();
      for (int v = 0; v < 6; v++) begin
         beats_q.push_back(rand_vec(1000));
         model_vector();
      end
      drive_all(st);
      wait_results(ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL b2b_timeout: got %0d results, required %0d", got_q.size(), exp_q.size()); end
      for (int j = 1; j < got_cyc.size(); j++) begin
         n_cmp++;
         if (got_cyc[j] - got_cyc[j-1] !== 1)
            begin n_err++; $display("FAIL b2b_spacing: got gap %0d cycles, required 1", got_cyc[j] - got_cyc[j-1]); end
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         n_cmp++;
         if (g !== e)
            begin n_err++; $display("FAIL b2b_result: got sum=%0d beats=%0d ovf=%0b, required sum=%0d beats=%0d ovf=%0b",
                                   $signed(g[RES_W-1 -: ACC_W]), g[CNT_W:1], g[0], $signed(e[RES_W-1 -: ACC_W]), e[CNT_W:1], e[0]); end
      end
   endtask

   task automatic test_backpressure();
      int               st;
      bit               ok;
      int               bad = 0;
      int               guard = 0;
      logic [RES_W+1:0] held;
      logic [RES_W-1:0] e, g;
      for (int v = 0; v < 3; v++) begin
         beats_q.push_back(rand_vec(500));
         beats_q.push_back(rand_vec(500));
         model_vector();
      end
      out_ready = 1'b0;
      fork
         drive_all(st);
         begin
            @(negedge clk);
            while (!out_valid && guard < 100) begin @(negedge clk); guard++; end
            n_cmp++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1)
               begin n_err++; $display("FAIL bp_in_ready_drop: got in_ready=%0b out_valid=%0b, required 0 and 1", in_ready, out_valid); end
            held = {out_valid, in_ready, out_sum, out_beats, overflow};
            repeat (10) begin
               @(negedge clk);
               if ({out_valid, in_ready, out_sum, out_beats, overflow} !== held) bad++;
            end
            n_cmp++;
            if (bad !== 0) begin n_err++; $display("FAIL bp_hold_stable: got %0d changed cycles, required 0", bad); end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      wait_results(ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL bp_timeout: got %0d results, required %0d", got_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         n_cmp++;
         if (g !== e)
            begin n_err++; $display("FAIL bp_result: got sum=%0d beats=%0d ovf=%0b, required sum=%0d beats=%0d ovf=%0b",
                                   $signed(g[RES_W-1 -: ACC_W]), g[CNT_W:1], g[0], $signed(e[RES_W-1 -: ACC_W]), e[CNT_W:1], e[0]); end
      end
   endtask

   task automatic test_sign_overflow_saturation();
      int               st;
      bit               ok;
      logic [RES_W-1:0] e, g;
      beats_q.push_back(fill(16'hFFFB));
      model_vector();
      beats_q.push_back(fill(16'h7FFF));
      beats_q.push_back(fill(16'h7FFF));
      model_vector();
      beats_q.push_back(fill(16'd1));
      model_vector();
      for (int j = 0; j < 20; j++) beats_q.push_back(fill(16'd1));
      model_vector();
      drive_all(st);
      wait_results(ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL edge_timeout: got %0d results, required %0d", got_q.size(), exp_q.size()); end
      for (int j = 0; j < 4 && got_q.size() > 0 && exp_q.size() > 0; j++) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         n_cmp++;
         if (g !== e)
            begin n_err++; $display("FAIL edge_result_%0d: got sum=%0d beats=%0d ovf=%0b, required sum=%0d beats=%0d ovf=%0b", j,
                                   $signed(g[RES_W-1 -: ACC_W]), g[CNT_W:1], g[0], $signed(e[RES_W-1 -: ACC_W]), e[CNT_W:1], e[0]); end
         n_cmp++;
         if (g[0] !== (j == 1))
            begin n_err++; $display("FAIL edge_overflow_%0d: got %0b, required %0b", j, g[0], (j == 1)); end
      end
   endtask

   task automatic test_random();
      int               st;
      bit               ok;
      bit               done = 1'b0;
      int               nb;
      logic [RES_W-1:0] e, g;
      for (int v = 0; v < 20; v++) begin
         nb = $urandom_range(4, 1);
         for (int j = 0; j < nb; j++) beats_q.push_back(rand_vec($urandom_range(1, 0) ? 32767 : 300));
         model_vector();
      end
      fork
         begin
            drive_all(st);
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(3, 0) != 0);
            end
            out_ready = 1'b1;
         end
      join
      wait_results(ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL random_timeout: got %0d results, required %0d", got_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         n_cmp++;
         if (g !== e)
            begin n_err++; $display("FAIL random_result: got sum=%0d beats=%0d ovf=%0b, required sum=%0d beats=%0d ovf=%0b",
                                   $signed(g[RES_W-1 -: ACC_W]), g[CNT_W:1], g[0], $signed(e[RES_W-1 -: ACC_W]), e[CNT_W:1], e[0]); end
      end
      n_cmp++;
      if (got_q.size() !== 0) begin n_err++; $display("FAIL random_extra: got %0d extra results, required 0", got_q.size()); end
   endtask

   task automatic test_reset_mid();
      int               st;
      bit               ok;
      beat_t            it;
      logic [RES_W-1:0] e, g;
      for (int j = 0; j < 2; j++) begin
         it.v = fill(16'd7);
         it.last = 1'b0;
         drv_q.push_back(it);
      end
      drive_all(st);
      #2;
      reset = 1'b1;
      #1;
      n_cmp++;
      if ({out_valid, out_sum, out_beats, overflow, busy, in_ready} !== {1'b0, 20'd0, 4'd0, 1'b0, 1'b0, 1'b1})
         begin n_err++; $display("FAIL midreset_outputs: got valid=%0b sum=%0d beats=%0d ovf=%0b busy=%0b in_ready=%0b, required 0 0 0 0 0 1",
                                out_valid, out_sum, out_beats, overflow, busy, in_ready); end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      got_q.delete();
      exp_q.delete();
      beats_q.push_back(fill(16'd2));
      model_vector();
      drive_all(st);
      wait_results(ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL midreset_timeout: got %0d results, required %0d", got_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         n_cmp++;
         if (g !== e || g !== {20'd32, 4'd1, 1'b0})
            begin n_err++; $display("FAIL midreset_result: got sum=%0d beats=%0d ovf=%0b, required sum=32 beats=1 ovf=0",
                                   $signed(g[RES_W-1 -: ACC_W]), g[CNT_W:1], g[0]); end
      end
      n_cmp++;
      if (got_q.size() !== 0) begin n_err++; $display("FAIL midreset_extra: got %0d extra results, required 0", got_q.size()); end
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_prod   = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      test_single_beat();
      test_three_beat();
      test_back_to_back();
      test_backpressure();
`ifndef PRODUCT_ACCUMULATOR_RELU_EN
      test_sign_overflow_saturation();
`else
      test_sign_overflow_saturation();
`endif
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
